// File: rtl/board_io_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | board_io_ctrl_if : key and multiplexed display signals of a starter board |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface board_io_ctrl_if #(
  parameter int NKEYS = 4,
  parameter int NDIG  = 4
);
  logic [NKEYS-1:0]  key;
  logic [NKEYS-1:0]  keys_db;
  logic [NKEYS-1:0]  keys_press;
  logic [4*NDIG-1:0] disp_val;
  logic [NDIG-1:0]   disp_dp;
  logic [NDIG-1:0]   disp_en;
  logic [7:0]        hex0;
  logic [NDIG-1:0]   dig;

  modport master (
    output key, disp_val, disp_dp, disp_en,
    input  keys_db, keys_press, hex0, dig
  );

  modport slave (
    input  key, disp_val, disp_dp, disp_en,
    output keys_db, keys_press, hex0, dig
  );
endinterface
`default_nettype wire

// File: rtl/board_io_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | board_io_ctrl : key debounce/press pulses and multiplexed hex display    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module board_io_ctrl #(
  parameter int NKEYS        = 4,
  parameter int NDIG         = 4,
  parameter int DEB_CYCLES   = 500000,
  parameter int SCAN_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int KEY_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW  = 1,
  parameter int DIG_ACT_LOW  = 1
) (
  input  wire logic      clk50mhz,
  input  wire logic      rst_key,
  board_io_ctrl_if.slave io
);

  localparam int         c_DW      = $clog2(DEB_CYCLES);
  localparam int         c_PW      = $clog2(SCAN_CYCLES);
  localparam int         c_IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic       c_KEY_REL = (KEY_ACT_LOW != 0);
  localparam logic       c_SEG_INV = (SEG_ACT_LOW != 0);
  localparam logic       c_DIG_INV = (DIG_ACT_LOW != 0);
  localparam logic [7:0] c_SEG_OFF = {8{c_SEG_INV}};

  logic [NKEYS-1:0] w_db;
  logic [NKEYS-1:0] w_press;

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic            r_sync1;
      logic            r_sync2;
      logic            r_db;
      logic            r_press;
      logic [c_DW-1:0] r_cnt;
      logic            w_pressed;

      assign w_pressed = r_sync2 ^ c_KEY_REL;

      always_ff @(posedge clk50mhz or negedge rst_key) begin
        if (!rst_key) begin
          r_sync1 <= c_KEY_REL;
          r_sync2 <= c_KEY_REL;
          r_db    <= 1'b0;
          r_press <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= io.key[gi];
          r_sync2 <= r_sync1;
          r_press <= 1'b0;
          if (w_pressed == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DW'(DEB_CYCLES - 1)) begin
            // Accept the change; pulse only when it is a press.
            r_db    <= ~r_db;
            r_cnt   <= '0;
            r_press <= w_pressed;
          end else begin
            r_cnt <= r_cnt + c_DW'(1);
          end
        end
      end

      assign w_db[gi]    = r_db;
      assign w_press[gi] = r_press;
    end
  endgenerate

  assign io.keys_db    = w_db;
  assign io.keys_press = w_press;

  logic [c_PW-1:0] r_pre;
  logic [c_IW-1:0] r_idx;
  logic [NDIG-1:0] r_dig;
  logic [7:0]      r_hex;
  logic [3:0]      w_nib;
  logic            w_dp;
  logic            w_en;
  logic [NDIG-1:0] w_onehot;
  logic [6:0]      w_seg7;
  logic            w_show;

  always_comb begin
    w_nib    = 4'h0;
    w_dp     = 1'b0;
    w_en     = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == c_IW'(i)) begin
        w_nib       = io.disp_val[4*i +: 4];
        w_dp        = io.disp_dp[i];
        w_en        = io.disp_en[i];
        w_onehot[i] = 1'b1;
      end
    end
    case (w_nib)
      4'h0:    w_seg7 = 7'h3F;
      4'h1:    w_seg7 = 7'h06;
      4'h2:    w_seg7 = 7'h5B;
      4'h3:    w_seg7 = 7'h4F;
      4'h4:    w_seg7 = 7'h66;
      4'h5:    w_seg7 = 7'h6D;
      4'h6:    w_seg7 = 7'h7D;
      4'h7:    w_seg7 = 7'h07;
      4'h8:    w_seg7 = 7'h7F;
      4'h9:    w_seg7 = 7'h6F;
      4'hA:    w_seg7 = 7'h77;
      4'hB:    w_seg7 = 7'h7C;
      4'hC:    w_seg7 = 7'h39;
      4'hD:    w_seg7 = 7'h5E;
      4'hE:    w_seg7 = 7'h79;
      default: w_seg7 = 7'h71;
    endcase
    // Dead time at the start of every slot keeps the previous digit from ghosting.
    w_show = (r_pre >= c_PW'(BLANK_CYCLES)) && w_en;
  end

  always_ff @(posedge clk50mhz or negedge rst_key) begin
    if (!rst_key) begin
      r_pre <= '0;
      r_idx <= '0;
      r_dig <= {NDIG{c_DIG_INV}};
      r_hex <= c_SEG_OFF;
    end else begin
      if (r_pre == c_PW'(SCAN_CYCLES - 1)) begin
        r_pre <= '0;
        r_idx <= (r_idx == c_IW'(NDIG - 1)) ? '0 : r_idx + c_IW'(1);
      end else begin
        r_pre <= r_pre + c_PW'(1);
      end
      if (w_show) begin
        r_dig <= w_onehot ^ {NDIG{c_DIG_INV}};
        r_hex <= {w_dp, w_seg7} ^ {8{c_SEG_INV}};
      end else begin
        r_dig <= {NDIG{c_DIG_INV}};
        r_hex <= c_SEG_OFF;
      end
    end
  end

  assign io.dig  = r_dig;
  assign io.hex0 = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_board_io_ctrl : scoreboard bench for board_io_ctrl                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_board_io_ctrl;
  localparam int NKEYS = 4;
  localparam int NDIG  = 4;

  typedef struct {
    int         cyc;
    logic [3:0] db;
    logic [3:0] press;
  } kev_t;

  typedef struct {
    int         cyc;
    logic [3:0] dig;
    logic [7:0] hex;
  } dev_t;

  logic clk     = 1'b0;
  logic rst_key = 1'b0;
  logic mon_en  = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   r0;
  int   q0;
  int   t;
  int   d;
  logic [3:0] en_s;
  logic [3:0] one = 4'b0001;
  logic [3:0] prev_db  = 4'h0;
  logic [3:0] prev_dig = 4'hF;
  logic [7:0] hexexp [4] = '{8'hC0, 8'h8E, 8'h30, 8'h88};
  kev_t key_q [$];
  dev_t disp_q [$];
  kev_t ke;
  dev_t de;

  board_io_ctrl_if #(.NKEYS(NKEYS), .NDIG(NDIG)) bus ();

  board_io_ctrl #(
    .NKEYS(NKEYS), .NDIG(NDIG), .DEB_CYCLES(8), .SCAN_CYCLES(20),
    .BLANK_CYCLES(2), .KEY_ACT_LOW(1), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
  ) dut (
    .clk50mhz (clk),
    .rst_key  (rst_key),
    .io       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic push_key(input int c, input logic [3:0] db, input logic [3:0] press);
    kev_t e;
    e.cyc = c; e.db = db; e.press = press;
    key_q.push_back(e);
  endtask

  task automatic push_disp(input int c, input logic [3:0] dg, input logic [7:0] hx);
    dev_t e;
    e.cyc = c; e.dig = dg; e.hex = hx;
    disp_q.push_back(e);
  endtask

  // Monitor: any key-level change/pulse or digit-select change is a DUT event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.keys_db !== prev_db || bus.keys_press !== 4'h0) begin
        if (key_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL key_unexpected db=%b press=%b required=none (cyc %0d)",
                   bus.keys_db, bus.keys_press, cyc);
        end else begin
          ke = key_q.pop_front();
          chk("key_cycle", cyc, ke.cyc);
          chk("keys_db", bus.keys_db, ke.db);
          chk("keys_press", bus.keys_press, ke.press);
        end
      end
      if (bus.dig !== prev_dig) begin
        if (disp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dig_unexpected dig=%b hex0=%h required=none (cyc %0d)",
                   bus.dig, bus.hex0, cyc);
        end else begin
          de = disp_q.pop_front();
          chk("dig_cycle", cyc, de.cyc);
          chk("dig", bus.dig, de.dig);
          chk("hex0", bus.hex0, de.hex);
        end
      end
    end
    prev_db  <= bus.keys_db;
    prev_dig <= bus.dig;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired (cyc %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bus.key = 4'hF; bus.disp_val = '0; bus.disp_dp = '0; bus.disp_en = '0;
    for (int i = 0; i < 2; i++) begin
      step(2);
      bus.key      = 4'($urandom);
      bus.disp_val = 16'($urandom);
      bus.disp_dp  = 4'($urandom);
      bus.disp_en  = 4'($urandom);
      @(negedge clk);
      chk("rst_keys_db", bus.keys_db, 4'h0);
      chk("rst_keys_press", bus.keys_press, 4'h0);
      chk("rst_dig", bus.dig, 4'hF);
      chk("rst_hex0", bus.hex0, 8'hFF);
    end
    step(1);
    bus.key = 4'hF; bus.disp_val = 16'hA3F0; bus.disp_dp = 4'b0100; bus.disp_en = 4'hF;
    step(1);
    rst_key = 1'b1;
    r0 = cyc;
    for (int s = 0; s < 19; s++) begin
      d    = s % 4;
      en_s = (s >= 8 && s < 16) ? 4'b1011 : 4'hF;
      if (en_s[d]) begin
        push_disp(r0 + 3 + 20*s, ~(one << d), hexexp[d]);
        if (s < 18) push_disp(r0 + 21 + 20*s, 4'hF, 8'hFF);
      end
    end
    mon_en = 1'b1;

    // Bounce on key 0, then a stable press.
    wait_until(r0 + 5);
    bus.key = 4'b1110; step(5);
    bus.key = 4'b1111; step(3);
    bus.key = 4'b1110; t = cyc;
    push_key(t + 10, 4'b0001, 4'b0001);
    step(20);
    bus.key = 4'b1111; t = cyc;
    push_key(t + 10, 4'b0000, 4'b0000);
    step(20);
    bus.key = 4'b0101; t = cyc;
    push_key(t + 10, 4'b1010, 4'b1010);
    step(20);
    bus.key = 4'b1111; t = cyc;
    push_key(t + 10, 4'b0000, 4'b0000);
    // One cycle short of the debounce window: must be ignored.
    step(15);
    bus.key = 4'b1011; step(7);
    bus.key = 4'b1111;
    // Exactly the debounce window: accepted, then released again.
    step(10);
    bus.key = 4'b1011; t = cyc;
    push_key(t + 10, 4'b0100, 4'b0100);
    step(8);
    bus.key = 4'b1111;
    push_key(t + 18, 4'b0000, 4'b0000);

    wait_until(r0 + 155);
    bus.disp_en = 4'b1011;
    wait_until(r0 + 330);
    bus.disp_en = 4'hF;

    // Reset in digit 2's slot with key 0's debounce count at 5.
    wait_until(r0 + 363);
    bus.key = 4'b1110;
    wait_until(r0 + 370);
    mon_en = 1'b0;
    chk("key_q_drained", key_q.size(), 0);
    chk("disp_q_drained", disp_q.size(), 0);
    rst_key = 1'b0;
    #1;
    chk("async_keys_db", bus.keys_db, 4'h0);
    chk("async_keys_press", bus.keys_press, 4'h0);
    chk("async_dig", bus.dig, 4'hF);
    chk("async_hex0", bus.hex0, 8'hFF);
    step(3);
    rst_key = 1'b1;
    q0 = cyc;
    push_key(q0 + 10, 4'b0001, 4'b0001);
    push_disp(q0 + 3, 4'b1110, 8'hC0);
    push_disp(q0 + 21, 4'hF, 8'hFF);
    mon_en = 1'b1;
    wait_until(q0 + 22);
    @(negedge clk);
    chk("key_q_final", key_q.size(), 0);
    chk("disp_q_final", disp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Reusable board-level I/O controller for the 50 MHz starter boards. It replaces the tied-off LED, 7-segment and digit outputs of the board top-levels with live logic.
- Per key: two-flop synchronisation, counter debounce, and a one-cycle press pulse.
- Display: time-multiplexed hex display over NDIG digits, with per-digit decimal point, blanking and an anti-ghosting dead time.
- Instantiated once per board top, beside the game wrapper.

Parameters:
- NKEYS, 4, number of push-button inputs.
- NDIG, 4, number of multiplexed 7-segment digits (at least 1).
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a key change (10 ms at 50 MHz); at least 2.
- SCAN_CYCLES, 50000, clock cycles each digit is selected (1 ms); at least 2.
- BLANK_CYCLES, 16, cycles at the start of each digit slot with all digits off; 0 to SCAN_CYCLES-1.
- KEY_ACT_LOW, 1, 1 means a raw key reads 0 when pressed.
- SEG_ACT_LOW, 1, 1 means segment and dp outputs are driven 0 to light.
- DIG_ACT_LOW, 1, 1 means digit enables are driven 0 to select.

Ports:
- clk50mhz, in, 1, system clock.
- rst_key, in, 1, asynchronous active-low reset.
- key, in, NKEYS, raw asynchronous button inputs.
- keys_db, out, NKEYS, debounced level; 1 means pressed regardless of KEY_ACT_LOW.
- keys_press, out, NKEYS, one-cycle pulse on each debounced press.
- disp_val, in, 4*NDIG, hex nibble per digit; digit i is bits [4i+3:4i].
- disp_dp, in, NDIG, decimal point per digit; 1 means lit.
- disp_en, in, NDIG, per-digit enable; 0 blanks that digit.
- hex0, out, 8, segments: bit7 = dp, bits 6..0 = g,f,e,d,c,b,a.
- dig, out, NDIG, one-hot digit select, polarity per DIG_ACT_LOW.

Behaviour:
- Reset (asynchronous, rst_key=0):
  - keys_db=0 and keys_press=0.
  - Synchroniser flops take the released level.
  - Debounce counters, prescaler and scan index go to 0.
  - dig is all-inactive and hex0 all-unlit, per the polarity parameters.
- All outputs are registered. Reset release is used directly (board-level reset); outputs resume one clock after the release edge.
- Key path, per key, independent:
  - Sample key through 2 flops, then normalise so that 1 means pressed.
  - When the synced value differs from keys_db, the counter increments.
  - When the synced value equals keys_db, the counter clears to 0.
  - When the counter equals DEB_CYCLES-1 while still differing: keys_db toggles and the counter clears.
  - Any glitch shorter than DEB_CYCLES cycles therefore never reaches keys_db.
  - Latency from a stable raw edge to keys_db is 2 + DEB_CYCLES cycles.
- Press pulse:
  - keys_press[i]=1 for exactly the one cycle in which keys_db[i] goes 0→1. It is registered together with keys_db, in the same cycle.
  - A release produces no pulse.
  - Simultaneous presses on several keys pulse in the same cycle.
- Scan:
  - The prescaler counts 0..SCAN_CYCLES-1.
  - At the terminal count, the index advances, wrapping from NDIG-1 to 0.
  - Digit order: 0,1,...,NDIG-1,0,...
- Output registers, each cycle, for current index i:
  - If prescaler < BLANK_CYCLES, or disp_en[i]=0: dig all-inactive, hex0 all-unlit.
  - Otherwise: dig has only bit i active; hex0[6:0] = decode(disp_val nibble i); hex0[7] = disp_dp[i].
  - Outputs lag the prescaler/index state by exactly 1 cycle.
  - disp_val, disp_dp and disp_en are sampled live; a change becomes visible on the next cycle of the relevant slot.
- Decode, active-high gfedcba, inverted when SEG_ACT_LOW=1:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- NDIG=1: the index stays 0 and blanking still applies every slot.
- Counter widths are $clog2 of the relevant parameter, with no overflow beyond the terminal count.

Test Plan (NKEYS=4, NDIG=4, DEB_CYCLES=8, SCAN_CYCLES=20, BLANK_CYCLES=2, all ACT_LOW=1):
- Reset:
  - Hold rst_key=0 with random inputs → keys_db=0, keys_press=0, dig=4'b1111, hex0=8'hFF.
  - Release → first digit-0 select when prescaler reaches 2 (output 1 cycle later).
- Debounce:
  - key[0]=0 for 5 cycles, then 1 for 3, then 0 held → no change during bounce.
  - keys_db[0]=1 exactly 2+8 cycles after the final stable edge.
  - keys_press[0] high for 1 cycle, coincident.
- Release and multi-key:
  - Release key[0] stably → keys_db[0]=0 after 10 cycles, no pulse.
  - Press key[1] and key[3] in the same cycle → both pulse in the same cycle.
- Scan and decode:
  - disp_val=16'hA3F0, disp_dp=4'b0100, disp_en=4'hF.
  - Digit 0: dig=1110, hex0=C0. Digit 1: dig=1101, hex0=8E. Digit 2: dig=1011, hex0=30. Digit 3: dig=0111, hex0=88.
  - Each slot is 20 cycles, with the first 2 at dig=1111; the sequence wraps back to digit 0.
- Blank enable: disp_en=4'b1011 → digit 2's slot shows dig=1111, hex0=FF for all 20 cycles; the other digits are unaffected.
- Reset mid-operation:
  - Assert rst_key during the digit-2 slot while a debounce count is at 5 → outputs reset immediately (asynchronously).
  - After release, the scan restarts at digit 0 and the debounce restarts from 0.
